simd_unpack: RTL and testbench
==============================

Name: simd_unpack

Overview:
- Reader side of the SIMD packed-lane format used by the vector lanes.
- Accepts one packed MAX_WIDTH-bit word together with its one-hot SEW.
- Streams the word's elements out one per handshake, lowest element first, each sign- or zero-extended to MAX_WIDTH.
- Sits between a vector register-file read port and scalar-width consumers such as the reduction unit or element-wise moves.

Parameters:
- MIN_WIDTH, 8, narrowest element width in bits.
- MAX_WIDTH, 64, packed word width and widest element width.
- SEW_WIDTH, $clog2(MAX_WIDTH/MIN_WIDTH)+1, width of the one-hot SEW field.
- RATIO (localparam), MAX_WIDTH/MIN_WIDTH, maximum number of elements per word.
- IDX_WIDTH (localparam), max($clog2(RATIO),1), element index width.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous, active-low.
- in_valid  in  1  packed word offered.
- in_ready  out  1  block can accept a word.
- in_data  in  MAX_WIDTH  packed word; element k occupies bits [k*W +: W].
- in_sew  in  SEW_WIDTH  one-hot element width; bit0 = MAX_WIDTH, bit1 = MAX_WIDTH/2, ..., bit SEW_WIDTH-1 = MIN_WIDTH.
- in_signed  in  1  1 = sign-extend elements, 0 = zero-extend.
- out_valid  out  1  element presented.
- out_ready  in  1  consumer takes the element.
- out_data  out  MAX_WIDTH  extended element.
- out_idx  out  IDX_WIDTH  element index within the word.
- out_last  out  1  final element of the current word.

Behaviour:
- Reset (rst_n low, asynchronous):
  - state = IDLE; out_valid = 0, out_data = 0, out_idx = 0, out_last = 0.
  - Internal data, sew, signed and count registers cleared.
  - in_ready = 1 once in IDLE.
- States:
  - IDLE: in_ready = 1, out_valid = 0.
  - BUSY: out_valid = 1.
- Accept (in_valid & in_ready):
  - Latch in_data, in_sew and in_signed.
  - Element width W = MAX_WIDTH >> (index of lowest set bit of in_sew); N = MAX_WIDTH/W.
  - in_sew == 0 is treated as bit0 (W = MAX_WIDTH, N = 1).
  - With more than one bit set, the lowest set bit wins.
  - idx = 0; go to BUSY.
- Latency: element 0 is valid the cycle after acceptance. Outputs are registered, with no combinational path from the in_* ports.
- BUSY outputs:
  - out_data = extend(word[idx*W +: W]).
  - out_idx = idx.
  - out_last = (idx == N-1).
- Advance (out_valid & out_ready & !out_last): idx++; next element on the following cycle.
- Last handoff (out_valid & out_ready & out_last):
  - in_ready = 1 in that same cycle (combinational from out_ready).
  - If in_valid is also high, the new word is latched and its element 0 appears next cycle: no bubble, state stays BUSY.
  - Otherwise go to IDLE.
- Backpressure: while out_ready = 0, out_data, out_idx and out_last hold stable and in_ready = 0.
- in_* values are ignored when no handshake occurs.
- Throughput: N elements in N cycles per word under full flow.
- Reset mid-word: the word is discarded; the first post-reset accepted word starts at idx 0.

Optional Feature:
- Macro: SIMD_UNPACK_MASK_EN.
- When defined:
  - Adds port in_mask (in, RATIO bits); bit k enables element k and is latched on accept.
  - Disabled elements are skipped without a cycle; out_idx still reports the true index.
  - out_last marks the highest enabled element.
  - A word with no enabled elements among its N is consumed on accept, produces no output, and leaves the state IDLE (or idle-equivalent).
  - in_mask bits at or above N are ignored.
- When not defined: no in_mask port; all N elements are emitted.

Test Plan:
- 8-bit signed:
  - Stimulus: in_data = 0x8877_6655_4433_2211, in_sew = 4'b1000, in_signed = 1, out_ready = 1.
  - Expect: 8 elements 0x11..0x77 zero-padded, then 0xFFFF_FFFF_FFFF_FF88 at out_idx 7 with out_last = 1; first output the cycle after accept.
- 16-bit unsigned:
  - Stimulus: same word, in_sew = 4'b0100, in_signed = 0.
  - Expect: 0x2211, 0x4433, 0x6655, 0x8877 at idx 0..3; out_last only on idx 3.
- 32-bit and 64-bit:
  - 32-bit signed: 0x4433_2211, then 0xFFFF_FFFF_8877_6655.
  - in_sew = 4'b0001: a single element equal to the word, out_last = 1.
  - in_sew = 0: same single-element result.
- Back-to-back and backpressure:
  - Two 16-bit words with in_valid held high: in_ready pulses on the last handshake, and word 2 idx 0 follows word 1 idx 3 with no gap.
  - out_ready low for 3 cycles mid-word: outputs stable, in_ready = 0.
- Reset mid-word: assert rst_n low after idx 2 of an 8-bit word → out_valid = 0 immediately; after release the next word starts at idx 0.
- SIMD_UNPACK_MASK_EN:
  - 8-bit word with in_mask = 0x24: only idx 2 and idx 5 are emitted, out_last on idx 5.
  - in_mask = 0x00: no output, in_ready = 1 the next cycle.

Source files
------------

// File: rtl/simd_unpack.sv
// simd_unpack: reader side of the SIMD packed-lane format.
// Accepts one packed MAX_WIDTH-bit word with a one-hot SEW and streams its
// elements out one per handshake, lowest element first, each sign- or
// zero-extended to MAX_WIDTH.
//
// Optional feature macro: SIMD_UNPACK_MASK_EN (adds in_mask element enables).
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   in_valid/in_ready   packed word handshake
//   in_data             packed word, element k at [k*W +: W]
//   in_sew              one-hot width: bit0 = MAX_WIDTH ... top bit = MIN_WIDTH
//   in_signed           1 = sign-extend, 0 = zero-extend
//   in_mask             (SIMD_UNPACK_MASK_EN only) per-element enable
//   out_valid/out_ready element handshake
//   out_data            extended element
//   out_idx             element index within the word
//   out_last            final (enabled) element of the current word
module simd_unpack #(
  parameter int unsigned MIN_WIDTH = 8,
  parameter int unsigned MAX_WIDTH = 64,
  parameter int unsigned SEW_WIDTH = $clog2(MAX_WIDTH / MIN_WIDTH) + 1,
  localparam int unsigned RATIO     = MAX_WIDTH / MIN_WIDTH,
  localparam int unsigned IDX_WIDTH = (RATIO > 1) ? $clog2(RATIO) : 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [MAX_WIDTH-1:0] in_data,
  input  logic [SEW_WIDTH-1:0] in_sew,
  input  logic                 in_signed,
`ifdef SIMD_UNPACK_MASK_EN
  input  logic [RATIO-1:0]     in_mask,
`endif
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [MAX_WIDTH-1:0] out_data,
  output logic [IDX_WIDTH-1:0] out_idx,
  output logic                 out_last
);

  localparam int unsigned SHW = $clog2(SEW_WIDTH) + 1;

  typedef enum logic {IDLE, BUSY} state_t;

  state_t state_q, state_d;

  logic [MAX_WIDTH-1:0] word_q;
  logic [SHW-1:0]       sh_q;    // log2 of element count; W = MAX_WIDTH >> sh_q
  logic                 sgn_q;
  logic [RATIO-1:0]     mask_q;

  logic                 accept, advance, found, more;
  logic [MAX_WIDTH-1:0] src_word, nxt_data;
  logic                 src_sgn;
  logic [RATIO-1:0]     src_mask;
  int unsigned          src_sh, start, first;

  function automatic logic [MAX_WIDTH-1:0] extract(
    input logic [MAX_WIDTH-1:0] word,
    input int unsigned          sh,
    input int unsigned          idx,
    input logic                 sgn
  );
    int unsigned          w;
    logic [MAX_WIDTH-1:0] sft, lm, res;
    w   = MAX_WIDTH >> sh;
    sft = word >> (idx * w);
    lm  = {MAX_WIDTH{1'b1}} >> (MAX_WIDTH - w);
    res = sft & lm;
    if (sgn && sft[w-1]) res = res | ~lm;
    return res;
  endfunction

  // A new word and an in-word advance share one element-selection path:
  // the source is either the incoming word (search from index 0) or the
  // held word (search from out_idx+1).
  always_comb begin
    accept   = in_valid & in_ready;
    advance  = out_valid & out_ready & ~out_last;
    src_word = word_q;
    src_sh   = 32'(sh_q);
    src_sgn  = sgn_q;
    src_mask = mask_q;
    start    = 32'(out_idx) + 1;
    if (accept) begin
      src_word = in_data;
      src_sh   = 0;
      for (int unsigned b = SEW_WIDTH; b > 0; b--) begin
        if (in_sew[b-1]) src_sh = b - 1;
      end
      src_sgn  = in_signed;
`ifdef SIMD_UNPACK_MASK_EN
      src_mask = in_mask;
`else
      src_mask = '1;
`endif
      start    = 0;
    end
    for (int unsigned k = 0; k < RATIO; k++) begin
      if (k >= (32'd1 << src_sh)) src_mask[k] = 1'b0;
    end
    found = 1'b0;
    first = 0;
    for (int unsigned k = RATIO; k > 0; k--) begin
      if ((k - 1) >= start && src_mask[k-1]) begin
        found = 1'b1;
        first = k - 1;
      end
    end
    more = 1'b0;
    for (int unsigned k = 0; k < RATIO; k++) begin
      if (found && k > first && src_mask[k]) more = 1'b1;
    end
    nxt_data = extract(src_word, src_sh, first, src_sgn);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (accept) state_d = found ? BUSY : IDLE;
      BUSY: begin
        if (accept)                    state_d = found ? BUSY : IDLE;
        else if (out_ready & out_last) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    out_valid = (state_q == BUSY);
    in_ready  = (state_q == IDLE) | (out_ready & out_last);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      word_q   <= '0;
      sh_q     <= '0;
      sgn_q    <= 1'b0;
      mask_q   <= '0;
      out_data <= '0;
      out_idx  <= '0;
      out_last <= 1'b0;
    end else if (accept | advance) begin
      word_q   <= src_word;
      sh_q     <= SHW'(src_sh);
      sgn_q    <= src_sgn;
      mask_q   <= src_mask;
      out_data <= nxt_data;
      out_idx  <= IDX_WIDTH'(first);
      out_last <= found & ~more;
    end else if (out_valid & out_ready & out_last) begin
      out_last <= 1'b0;
    end
  end

endmodule

// File: tb/tb_simd_unpack.sv
module tb_simd_unpack;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [63:0] in_data = '0;
  logic [3:0]  in_sew = '0;
  logic        in_signed = 1'b0;
  logic [7:0]  mask_v = 8'hFF;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [63:0] out_data;
  logic [2:0]  out_idx;
  logic        out_last;

  int checks = 0;
  int errors = 0;
  int rdy_mode = 0;  // 0: always ready, 1: random, 2: stalled
  int cyc = 0;

  typedef struct {
    logic [63:0] data;
    int          idx;
    bit          last;
  } exp_t;
  exp_t q[$];

  localparam logic [63:0] WORD = 64'h8877_6655_4433_2211;

  simd_unpack dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_sew(in_sew), .in_signed(in_signed),
`ifdef SIMD_UNPACK_MASK_EN
    .in_mask(mask_v),
`endif
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_idx(out_idx), .out_last(out_last)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Reference model: plain wide arithmetic on the element definition.
  function automatic logic [63:0] elem(logic [63:0] d, int w, int k, bit sgn);
    logic [127:0] big, lm, e;
    big = {64'b0, d} >> (k * w);
    lm  = (128'd1 << w) - 128'd1;
    e   = big & lm;
    if (sgn && big[w-1]) e = e | ~lm;
    return e[63:0];
  endfunction

  function automatic int width_of(logic [3:0] sew);
    int sh = 0;
    for (int b = 3; b >= 0; b--) if (sew[b]) sh = b;
    return 64 >> sh;
  endfunction

  function automatic void push_word(logic [63:0] d, logic [3:0] sew, bit sgn, logic [7:0] m);
    int w, n, last_k;
    exp_t e;
    w = width_of(sew);
    n = 64 / w;
    last_k = -1;
    for (int k = 0; k < n; k++) if (m[k]) last_k = k;
    for (int k = 0; k < n; k++) begin
      if (m[k]) begin
        e.data = elem(d, w, k, sgn);
        e.idx  = k;
        e.last = (k == last_k);
        q.push_back(e);
      end
    end
  endfunction

  // Per-cycle compare against the model queue, sampled mid-cycle.
  always @(negedge clk) begin
    if (!rst_n) begin
      q.delete();
      chk("rst_out_valid", 64'(out_valid), 64'd0);
      chk("rst_in_ready", 64'(in_ready), 64'd1);
    end else begin
      chk("out_valid", 64'(out_valid), 64'(q.size() > 0));
      if (q.size() > 0) begin
        chk("out_data", out_data, q[0].data);
        chk("out_idx", 64'(out_idx), 64'(q[0].idx));
        chk("out_last", 64'(out_last), 64'(q[0].last));
        chk("in_ready_busy", 64'(in_ready), 64'(out_ready && q[0].last));
        if (out_ready) void'(q.pop_front());
      end else begin
        chk("in_ready_idle", 64'(in_ready), 64'd1);
      end
      if (in_valid && in_ready) begin
`ifdef SIMD_UNPACK_MASK_EN
        push_word(in_data, in_sew, in_signed, mask_v);
`else
        push_word(in_data, in_sew, in_signed, 8'hFF);
`endif
      end
    end
  end

  initial forever begin
    @(posedge clk);
    #2;
    case (rdy_mode)
      0:       out_ready = 1'b1;
      1:       out_ready = ($urandom_range(9) < 7);
      default: out_ready = 1'b0;
    endcase
  end

  // Called at posedge+1; returns at posedge+1 after the accepting edge.
  task automatic send(logic [63:0] d, logic [3:0] s, logic sg, logic [7:0] m);
    int n;
    n = 0;
    in_valid = 1'b1; in_data = d; in_sew = s; in_signed = sg; mask_v = m;
    @(negedge clk);
    while (!in_ready && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      checks++; errors++;
      $display("FAIL send_timeout actual=in_ready_low required=accept");
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    in_valid = 1'b0;
    in_data  = {$urandom, $urandom};
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (q.size() > 0 && n < 3000) begin
      @(posedge clk);
      #1;
      n++;
    end
    checks++;
    if (q.size() > 0) begin
      errors++;
      $display("FAIL drain_timeout actual=%0d required=0", q.size());
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [63:0] hold_d;
    logic [2:0]  hold_i;
    int t1, t2;
    logic [3:0] sews [5] = '{4'b0000, 4'b0001, 4'b0010, 4'b0100, 4'b1000};

    // Model pins against hand-computed values.
    chk("model_8s_e0", elem(WORD, 8, 0, 1'b1), 64'h11);
    chk("model_8s_e7", elem(WORD, 8, 7, 1'b1), 64'hFFFF_FFFF_FFFF_FF88);
    chk("model_16u_e3", elem(WORD, 16, 3, 1'b0), 64'h8877);
    chk("model_32s_e1", elem(WORD, 32, 1, 1'b1), 64'hFFFF_FFFF_8877_6655);
    chk("model_sew0_w", 64'(width_of(4'b0000)), 64'd64);
    chk("model_multi_w", 64'(width_of(4'b1010)), 64'd32);

    // Reset state.
    repeat (2) @(posedge clk);
    #1;
    chk("reset_out_data", out_data, 64'd0);
    chk("reset_out_idx", 64'(out_idx), 64'd0);
    chk("reset_out_last", 64'(out_last), 64'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Directed widths.
    send(WORD, 4'b1000, 1'b1, 8'hFF); idle_in();
    chk("lat_8s_valid", 64'(out_valid), 64'd1);
    chk("lat_8s_data", out_data, 64'h11);
    wait_drain();
    send(WORD, 4'b0100, 1'b0, 8'hFF); idle_in(); wait_drain();
    send(WORD, 4'b0010, 1'b1, 8'hFF); idle_in(); wait_drain();
    send(WORD, 4'b0001, 1'b1, 8'hFF); idle_in();
    chk("w64_data", out_data, WORD);
    chk("w64_last", 64'(out_last), 64'd1);
    wait_drain();
    send(WORD, 4'b0000, 1'b0, 8'hFF); idle_in();
    chk("sew0_data", out_data, WORD);
    wait_drain();

    // Back-to-back 16-bit words: word 2 is accepted on word 1's last handoff.
    send(WORD, 4'b0100, 1'b0, 8'hFF);
    t1 = cyc;
    send(~WORD, 4'b0100, 1'b1, 8'hFF);
    t2 = cyc;
    idle_in();
    chk("b2b_gap", 64'(t2 - t1), 64'd4);
    chk("b2b_idx0", 64'(out_idx), 64'd0);
    chk("b2b_data0", out_data, 64'hFFFF_FFFF_FFFF_DDEE);
    wait_drain();

    // Backpressure mid-word.
    send(WORD, 4'b1000, 1'b0, 8'hFF); idle_in();
    @(posedge clk);
    #1;
    rdy_mode = 2;
    @(negedge clk);
    hold_d = out_data;
    hold_i = out_idx;
    chk("bp_idx", 64'(hold_i), 64'd1);
    chk("bp_in_ready", 64'(in_ready), 64'd0);
    repeat (2) begin
      @(negedge clk);
      chk("bp_data_hold", out_data, hold_d);
      chk("bp_idx_hold", 64'(out_idx), 64'(hold_i));
      chk("bp_in_ready", 64'(in_ready), 64'd0);
    end
    @(posedge clk);
    #1;
    rdy_mode = 0;
    wait_drain();

    // Reset mid-word after idx 2 is consumed.
    send(WORD, 4'b1000, 1'b1, 8'hFF); idle_in();
    repeat (3) begin @(posedge clk); #1; end
    rst_n = 1'b0;
    #1;
    chk("midrst_valid", 64'(out_valid), 64'd0);
    repeat (2) begin @(posedge clk); #1; end
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    send(WORD, 4'b1000, 1'b0, 8'hFF); idle_in();
    chk("postrst_idx", 64'(out_idx), 64'd0);
    wait_drain();

`ifdef SIMD_UNPACK_MASK_EN
    send(WORD, 4'b1000, 1'b0, 8'h24); idle_in();
    chk("mask_first_idx", 64'(out_idx), 64'd2);
    wait_drain();
    send(WORD, 4'b1000, 1'b0, 8'h00); idle_in();
    @(negedge clk);
    chk("mask0_valid", 64'(out_valid), 64'd0);
    chk("mask0_ready", 64'(in_ready), 64'd1);
    send(WORD, 4'b0100, 1'b1, 8'hF0); idle_in();  // only bits >= N set
    @(negedge clk);
    chk("mask_hi_valid", 64'(out_valid), 64'd0);
    @(posedge clk);
    #1;
`endif

    // Randomized traffic under random backpressure.
    rdy_mode = 1;
    for (int i = 0; i < 200; i++) begin
      logic [3:0] s;
      s = ($urandom_range(4) == 0) ? 4'($urandom) : sews[$urandom_range(4)];
      send({$urandom, $urandom}, s, 1'($urandom), 8'($urandom));
      if ($urandom_range(3) == 0) begin
        idle_in();
        repeat ($urandom_range(3)) begin @(posedge clk); #1; end
      end
    end
    idle_in();
    rdy_mode = 0;
    wait_drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1);
  end

endmodule
